// File: rtl/mastermind_pkg.sv
// Shared widths and FSM state encoding for the guess checker.
package mastermind_pkg;
  localparam int DIGIT_W     = 3;
  localparam int NUM_DIGITS  = 4;
  localparam int CODE_W      = 12;
  localparam int NUM_COLOURS = 8;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    EVAL_X,
    EVAL_P,
    REPORT,
    DONE
  } state_t;
endpackage

// File: rtl/colour_counter.sv
// Combinational count of how many digits of a code equal one colour.
module colour_counter
  import mastermind_pkg::*;
(
  input  logic [CODE_W-1:0]  code,
  input  logic [DIGIT_W-1:0] colour,
  output logic [2:0]         count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (code[i*DIGIT_W +: DIGIT_W] == colour) count = count + 3'd1;
    end
  end

endmodule

// File: rtl/guess_checker.sv
// Mastermind-style guess checker: digit entry, exact scoring and, with
// PARTIAL_MATCH_EN defined, a colour-by-colour partial-match pass.
module guess_checker
  import mastermind_pkg::*;
#(
  parameter int MAX_TRIES = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_code,
  input  logic              active_p,
  input  logic [CODE_W-1:0] R1,
  input  logic [2:0]        SW,
  input  logic              enter,
  output logic [2:0]        exact,
  output logic [2:0]        partial,
  output logic              result_valid,
  output logic [3:0]        tries,
  output logic              busy,
  output logic              win,
  output logic              lose,
  output logic              breaker_p
);

  state_t            state;
  logic [CODE_W-1:0] secret;
  logic [CODE_W-1:0] guess;
  logic [1:0]        idx;
  logic [2:0]        x_now;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'd15) ? v : v + 4'd1;
  endfunction

  always_comb begin
    x_now = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (secret[i*DIGIT_W +: DIGIT_W] == guess[i*DIGIT_W +: DIGIT_W]) x_now = x_now + 3'd1;
    end
  end

`ifdef PARTIAL_MATCH_EN
  logic [DIGIT_W-1:0] colour;
  logic [2:0]         acc;
  logic [2:0]         x_cnt;
  logic [2:0]         cnt_s;
  logic [2:0]         cnt_g;
  logic [2:0]         min_c;

  function automatic logic [2:0] min_count(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

  colour_counter u_cnt_secret (.code(secret), .colour(colour), .count(cnt_s));
  colour_counter u_cnt_guess  (.code(guess),  .colour(colour), .count(cnt_g));

  assign min_c = min_count(cnt_s, cnt_g);
`else
  assign partial = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      secret       <= '0;
      guess        <= '0;
      idx          <= '0;
      exact        <= '0;
      tries        <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
      breaker_p    <= 1'b0;
`ifdef PARTIAL_MATCH_EN
      colour       <= '0;
      acc          <= '0;
      x_cnt        <= '0;
      partial      <= '0;
`endif
    end else if (take_code) begin
      // A new code restarts the round from any state, discarding any pending digit.
      state        <= ENTRY;
      secret       <= R1;
      breaker_p    <= ~active_p;
      guess        <= '0;
      idx          <= '0;
      tries        <= '0;
      win          <= 1'b0;
      lose         <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
`ifdef PARTIAL_MATCH_EN
      colour       <= '0;
      acc          <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state)
        ENTRY: begin
          if (enter) begin
            guess <= {guess[CODE_W-DIGIT_W-1:0], SW};
            idx   <= idx + 2'd1;
            if (idx == 2'd3) begin
              state <= EVAL_X;
              busy  <= 1'b1;
            end
          end
        end
        EVAL_X: begin
`ifdef PARTIAL_MATCH_EN
          x_cnt  <= x_now;
          colour <= '0;
          acc    <= '0;
          state  <= EVAL_P;
`else
          exact        <= x_now;
          tries        <= sat_inc(tries);
          result_valid <= 1'b1;
          state        <= REPORT;
`endif
        end
`ifdef PARTIAL_MATCH_EN
        EVAL_P: begin
          // Sum of per-colour minima counts exact hits too, so remove them here.
          if (colour == 3'd7) begin
            partial      <= acc + min_c - x_cnt;
            exact        <= x_cnt;
            tries        <= sat_inc(tries);
            result_valid <= 1'b1;
            state        <= REPORT;
          end else begin
            acc    <= acc + min_c;
            colour <= colour + 3'd1;
          end
        end
`endif
        REPORT: begin
          busy <= 1'b0;
          if (exact == 3'd4) begin
            win   <= 1'b1;
            state <= DONE;
          end else if (tries == 4'(MAX_TRIES)) begin
            lose  <= 1'b1;
            state <= DONE;
          end else begin
            state <= ENTRY;
          end
        end
        IDLE, DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
